alu_issue_ctrl: RTL

Single-issue sequencer in front of the combinational ALU (OP/CMD-controlled, NZCV flag output).
- Accepts one data-processing, memory-address or branch-target request at a time.
- Evaluates the ARM condition field against the architectural flag register it owns.
- Drives registered operands and controls into the ALU, captures the result, and commits flags under S-bit/CMP rules.
- Returns the result over a valid/ready writeback handshake. Sits between decode and register-file writeback.

---
 rtl/alu_issue_ctrl_if.sv | 27 ++
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request and writeback handshake bundle between decode/writeback and the ALU issue controller.
interface alu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cond;
   logic [1:0]  req_op;
   logic [3:0]  req_cmd;
   logic        req_s;
   logic [3:0]  req_rd;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        wb_valid;
   logic        wb_ready;
   logic        wb_we;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;

   modport master (
      output req_valid, req_cond, req_op, req_cmd, req_s, req_rd, req_a, req_b, wb_ready,
      input  req_ready, wb_valid, wb_we, wb_rd, wb_data
   );

   modport slave (
      input  req_valid, req_cond, req_op, req_cmd, req_s, req_rd, req_a, req_b, wb_ready,
      output req_ready, wb_valid, wb_we, wb_rd, wb_data
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer in front of a combinational ALU: condition check against the
// owned NZCV register, one EXEC cycle, then a held valid/ready writeback response.
module alu_issue_ctrl #(
   parameter logic [3:0] RST_FLAGS = 4'b0000,
   parameter int         CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   alu_issue_ctrl_if.slave  bus,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [1:0]       alu_op,
   output logic [3:0]       alu_cmd,
   input  logic [31:0]      alu_result,
   input  logic [3:0]       alu_flags,
   output logic [3:0]       flags,
   input  logic             flags_wr_en,
   input  logic [3:0]       flags_wr_data,
   input  logic             flush,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam logic [3:0] CMD_CMP = 4'b1010;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t state;
   logic   s_q;
   logic   is_cmp;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'h0:    cond_pass = z;
         4'h1:    cond_pass = !z;
         4'h2:    cond_pass = cf;
         4'h3:    cond_pass = !cf;
         4'h4:    cond_pass = n;
         4'h5:    cond_pass = !n;
         4'h6:    cond_pass = v;
         4'h7:    cond_pass = !v;
         4'h8:    cond_pass = cf && !z;
         4'h9:    cond_pass = !cf || z;
         4'hA:    cond_pass = (n == v);
         4'hB:    cond_pass = (n != v);
         4'hC:    cond_pass = !z && (n == v);
         4'hD:    cond_pass = z || (n != v);
         default: cond_pass = 1'b1;
      endcase
   endfunction

   assign is_cmp        = (alu_op == 2'd0) && (alu_cmd == CMD_CMP);
   assign bus.req_ready = (state == IDLE) && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         flags        <= RST_FLAGS;
         retired_cnt  <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         alu_cmd      <= '0;
         s_q          <= 1'b0;
         bus.wb_valid <= 1'b0;
         bus.wb_we    <= 1'b0;
         bus.wb_rd    <= '0;
         bus.wb_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  bus.wb_rd <= bus.req_rd;
                  if (cond_pass(bus.req_cond, flags)) begin
                     alu_a   <= bus.req_a;
                     alu_b   <= bus.req_b;
                     alu_op  <= bus.req_op;
                     alu_cmd <= bus.req_cmd;
                     s_q     <= bus.req_s;
                     state   <= EXEC;
                  end else begin
                     // Failed condition retires without a register write.
                     bus.wb_we    <= 1'b0;
                     bus.wb_data  <= '0;
                     bus.wb_valid <= 1'b1;
                     state        <= WB;
                  end
               end
            end
            EXEC: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  bus.wb_data  <= alu_result;
                  bus.wb_we    <= !is_cmp;
                  bus.wb_valid <= 1'b1;
                  state        <= WB;
                  if (alu_op == 2'd0 && (s_q || is_cmp))
                     flags <= alu_flags;
               end
            end
            WB: begin
               if (flush) begin
                  bus.wb_valid <= 1'b0;
                  state        <= IDLE;
               end else if (bus.wb_ready) begin
                  bus.wb_valid <= 1'b0;
                  retired_cnt  <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Placed last so an external write overrides a same-cycle EXEC commit.
         if (flags_wr_en)
            flags <= flags_wr_data;
      end
   end

endmodule
